// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its driver/observer.
// Optional mismatch-capture signals appear when TTS_MISMATCH_CAPTURE_EN is defined.
interface truth_table_sequencer_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic                   abort;
    logic                   f_in;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   table_q;
`ifdef TTS_MISMATCH_CAPTURE_EN
    logic [N_IN-1:0]        first_bad;
    logic [N_IN:0]          bad_cnt;

    modport master (output start, abort, f_in,
                    input  vec, busy, done, pass, table_q, first_bad, bad_cnt);
    modport slave  (input  start, abort, f_in,
                    output vec, busy, done, pass, table_q, first_bad, bad_cnt);
`else
    modport master (output start, abort, f_in,
                    input  vec, busy, done, pass, table_q);
    modport slave  (input  start, abort, f_in,
                    output vec, busy, done, pass, table_q);
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Exhaustive sweep of an N_IN-input combinational function, capturing f_in into table_q and
// comparing to EXPECTED. Define TTS_MISMATCH_CAPTURE_EN to add first_bad / bad_cnt outputs.
module truth_table_sequencer #(
    parameter int                   N_IN     = 4,
    parameter int                   SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'h0DD0
) (
    input logic                    clk,
    input logic                    rst,
    truth_table_sequencer_if.slave bus
);
    localparam int         W         = 1 << N_IN;
    localparam logic [3:0] HOLD_INIT = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] vec;
    logic [3:0]      hold;
    logic [W-1:0]    table_q, table_nxt;
    logic            pass;
    logic            go, last, sample;

    // abort beats start in IDLE; abort in RUN also suppresses that edge's sample
    assign go     = (state == IDLE) && bus.start && !bus.abort;
    assign last   = (vec == {N_IN{1'b1}});
    assign sample = (state == RUN) && !bus.abort && (hold == 4'd0);

    always_comb begin
        table_nxt      = table_q;
        table_nxt[vec] = bus.f_in;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (bus.abort) state_nxt = IDLE;
                     else if (sample && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    // pass is computed from the final table on the closing edge so it is valid alongside done
    always_ff @(posedge clk) begin
        if (rst) begin
            vec     <= '0;
            hold    <= 4'd0;
            table_q <= '0;
            pass    <= 1'b0;
        end else if (go) begin
            vec     <= '0;
            hold    <= HOLD_INIT;
            table_q <= '0;
            pass    <= 1'b0;
        end else if (state == RUN) begin
            if (bus.abort) begin
                vec  <= '0;
                pass <= 1'b0;
            end else if (sample) begin
                table_q <= table_nxt;
                if (last) begin
                    vec  <= '0;
                    pass <= (table_nxt == EXPECTED);
                end else begin
                    vec  <= vec + N_IN'(1);
                    hold <= HOLD_INIT;
                end
            end else begin
                hold <= hold - 4'd1;
            end
        end
    end

    assign bus.vec     = vec;
    assign bus.table_q = table_q;
    assign bus.pass    = pass;

`ifdef TTS_MISMATCH_CAPTURE_EN
    logic [N_IN-1:0] first_bad;
    logic [N_IN:0]   bad_cnt;

    // a zero count doubles as "no mismatch seen yet"
    always_ff @(posedge clk) begin
        if (rst || go) begin
            first_bad <= '0;
            bad_cnt   <= '0;
        end else if (sample && (bus.f_in != EXPECTED[vec])) begin
            if (bad_cnt == '0) first_bad <= vec;
            bad_cnt <= bad_cnt + (N_IN+1)'(1);
        end
    end

    assign bus.first_bad = first_bad;
    assign bus.bad_cnt   = bad_cnt;
`endif
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: default build plus a SETTLE=0 instance.
// Extra checks apply when TTS_MISMATCH_CAPTURE_EN is defined.
module tb_truth_table_sequencer;
    localparam logic [15:0] GOLD = 16'h0DD0;

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        int          first;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   mode;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    truth_table_sequencer_if #(.N_IN(4)) bus ();
    truth_table_sequencer_if #(.N_IN(4)) bus0 ();

    truth_table_sequencer #(.N_IN(4), .SETTLE(2), .EXPECTED(GOLD)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    truth_table_sequencer #(.N_IN(4), .SETTLE(0), .EXPECTED(GOLD)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));

    // mode 0: f=(a^b)&(c|~d); 1: constant 0; 2: correct with vector 10 inverted
    function automatic logic fmodel(input logic [3:0] v, input int m);
        logic f;
        f = (v[3] ^ v[2]) & (v[1] | ~v[0]);
        if (m == 1) f = 1'b0;
        if (m == 2 && v == 4'd10) f = ~f;
        return f;
    endfunction

    function automatic logic [15:0] exp_table(input int m);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = fmodel(4'(i), m);
        return t;
    endfunction

    assign bus.f_in  = fmodel(bus.vec, mode);
    assign bus0.f_in = fmodel(bus0.vec, 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // pushes the expectation, starts a sweep, pops and compares on the done pulse
    task automatic run_sweep(input int m, input bit hold_start, output int cycles, output int busy_n);
        exp_t e;
        logic [15:0] diff;
        mode   = m;
        e.tbl  = exp_table(m);
        e.pass = (e.tbl == GOLD);
        diff   = e.tbl ^ GOLD;
        e.cnt  = $countones(diff);
        e.first = 0;
        for (int i = 15; i >= 0; i--) if (diff[i]) e.first = i;
        sb.push_back(e);
        bus.start = 1'b1;
        tick();
        if (!hold_start) bus.start = 1'b0;
        cycles = 1;
        busy_n = 0;
        while (!bus.done && cycles < 200) begin
            busy_n += int'(bus.busy);
            tick();
            cycles++;
        end
        chk("sweep_done_seen", bus.done, 1);
        e = sb.pop_front();
        chk("table_q", bus.table_q, e.tbl);
        chk("pass", bus.pass, e.pass);
`ifdef TTS_MISMATCH_CAPTURE_EN
        chk("bad_cnt", bus.bad_cnt, e.cnt);
        if (e.cnt != 0) chk("first_bad", bus.first_bad, e.first);
`endif
    endtask

    initial begin
        int cyc, bsy, dones, verr;
        rst = 1'b1;
        mode = 0;
        bus.start = 1'b0;  bus.abort = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_table", bus.table_q, 0);
        chk("rst_vec", bus.vec, 0);

        // correct function
        run_sweep(0, 1'b0, cyc, bsy);
        chk("t1_done_cycle", cyc, 49);
        chk("t1_busy_cycles", bsy, 48);
        chk("t1_table_lit", bus.table_q, 16'h0DD0);
        tick();
        chk("t1_done_pulse", bus.done, 0);
        chk("t1_pass_held", bus.pass, 1);
        chk("t1_idle_busy", bus.busy, 0);

        // constant 0 and single-bit fault
        run_sweep(1, 1'b0, cyc, bsy);
        chk("t2_table_lit", bus.table_q, 16'h0000);
        tick();
        run_sweep(2, 1'b0, cyc, bsy);
        chk("t3_table_lit", bus.table_q, 16'h09D0);
        tick();

        // start with abort in IDLE stays idle
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("sa_idle_busy", bus.busy, 0);

        // abort on RUN cycle 20: vectors 0..5 captured so far
        run_sweep(0, 1'b0, cyc, bsy);
        tick();
        mode = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        chk("t4_busy_before", bus.busy, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_busy", bus.busy, 0);
        chk("t4_vec", bus.vec, 0);
        chk("t4_pass", bus.pass, 0);
        chk("t4_partial", bus.table_q, exp_table(0) & 16'h003F);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            dones += int'(bus.done);
            tick();
        end
        chk("t4_no_done", dones, 0);

        // reset at RUN cycle 30, then a clean sweep
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 30; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", bus.busy, 0);
        chk("t5_vec", bus.vec, 0);
        chk("t5_table", bus.table_q, 0);
        chk("t5_done", bus.done, 0);
        run_sweep(0, 1'b0, cyc, bsy);
        chk("t5_cycle", cyc, 49);
        chk("t5_pass", bus.pass, 1);
        tick();

        // start held high: one sweep, restart only from IDLE
        run_sweep(0, 1'b1, cyc, bsy);
        chk("t6_cycle", cyc, 49);
        chk("t6_busy_cycles", bsy, 48);
        tick();
        chk("t6_idle", bus.busy, 0);
        chk("t6_done_pulse", bus.done, 0);
        tick();
        chk("t6_reentry", bus.busy, 1);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t6_aborted", bus.busy, 0);

        // SETTLE=0 instance: vec steps every cycle
        chk("s0_rst_busy", bus0.busy, 0);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        cyc = 1; bsy = 0; verr = 0;
        while (!bus0.done && cyc < 100) begin
            bsy += int'(bus0.busy);
            if (bus0.vec != 4'(cyc - 1)) verr++;
            tick();
            cyc++;
        end
        chk("s0_done_seen", bus0.done, 1);
        chk("s0_cycle", cyc, 17);
        chk("s0_busy_cycles", bsy, 16);
        chk("s0_vec_steps", verr, 0);
        chk("s0_table", bus0.table_q, exp_table(0));
        chk("s0_pass", bus0.pass, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
